// File: rtl/error_encoder.sv
// Priority-serialises latched ERROR/STOP/WARNING requests onto the decoder's 3-bit message bus.
// Latency: request at edge k -> message at edge k+1 when idle; no backpressure, repeat requests coalesce while pending.
module error_encoder #(
    parameter int MSG_LEN = 3,
    parameter int GAP     = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_pending,
    input  logic             err_spill,
    input  logic             err_event,
    input  logic             mem_afull,
    input  logic             energy_err,
    output logic [2:0]       out_bus,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_stop,
    output logic [CNT_W-1:0] cnt_warn
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t           r_state;
    logic [7:0]       r_phase;
    logic             r_afull_prev;
    logic             r_pend_err;
    logic             r_pend_stop;
    logic             r_pend_warn;
    logic [2:0]       r_out_bus;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt_err;
    logic [CNT_W-1:0] r_cnt_stop;
    logic [CNT_W-1:0] r_cnt_warn;

    logic       w_req_err;
    logic       w_req_stop;
    logic       w_req_warn;
    logic       w_gnt_err;
    logic       w_gnt_stop;
    logic       w_gnt_warn;
    logic       w_launch;
    logic [1:0] w_code;

    assign w_req_err  = err_pending | err_spill | err_event;
    assign w_req_stop = mem_afull & ~r_afull_prev;
    assign w_req_warn = energy_err;

    assign w_gnt_err  = r_pend_err;
    assign w_gnt_stop = ~r_pend_err & r_pend_stop;
    assign w_gnt_warn = ~r_pend_err & ~r_pend_stop & r_pend_warn;
    assign w_code     = w_gnt_err ? 2'b00 : (w_gnt_stop ? 2'b10 : 2'b11);

    // Launch only from IDLE or the final GAP cycle, so back-to-back spacing is exactly GAP.
    assign w_launch = (r_pend_err | r_pend_stop | r_pend_warn) &
                      ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_phase == 8'(GAP - 1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_afull_prev <= 1'b0;
            r_pend_err   <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_warn  <= 1'b0;
            r_out_bus    <= 3'b000;
            r_busy       <= 1'b0;
            r_cnt_err    <= '0;
            r_cnt_stop   <= '0;
            r_cnt_warn   <= '0;
        end else begin
            r_afull_prev <= mem_afull;
            // A request on the grant edge keeps the flag set so another message follows.
            r_pend_err   <= w_req_err  | (r_pend_err  & ~(w_launch & w_gnt_err));
            r_pend_stop  <= w_req_stop | (r_pend_stop & ~(w_launch & w_gnt_stop));
            r_pend_warn  <= w_req_warn | (r_pend_warn & ~(w_launch & w_gnt_warn));

            if (w_launch) begin
                r_state   <= S_SEND;
                r_phase   <= '0;
                r_out_bus <= {1'b1, w_code};
                r_busy    <= 1'b1;
                if (w_gnt_err  && (r_cnt_err  != {CNT_W{1'b1}})) r_cnt_err  <= r_cnt_err  + 1'b1;
                if (w_gnt_stop && (r_cnt_stop != {CNT_W{1'b1}})) r_cnt_stop <= r_cnt_stop + 1'b1;
                if (w_gnt_warn && (r_cnt_warn != {CNT_W{1'b1}})) r_cnt_warn <= r_cnt_warn + 1'b1;
            end else begin
                case (r_state)
                    S_SEND: begin
                        if (r_phase == 8'(MSG_LEN - 1)) begin
                            r_state   <= S_GAP;
                            r_phase   <= '0;
                            r_out_bus <= 3'b000;
                        end else begin
                            r_phase <= r_phase + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (r_phase == 8'(GAP - 1)) begin
                            r_state <= S_IDLE;
                            r_phase <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_phase <= r_phase + 8'd1;
                        end
                    end
                    default: begin
                        r_phase <= '0;
                    end
                endcase
            end
        end
    end

    assign out_bus  = r_out_bus;
    assign busy     = r_busy;
    assign cnt_err  = r_cnt_err;
    assign cnt_stop = r_cnt_stop;
    assign cnt_warn = r_cnt_warn;

endmodule

// File: tb/tb_error_encoder.sv
// Bench for error_encoder: vector table, directed corner sequences and a randomized run against a timeline model.
module tb_error_encoder;

    localparam int ML = 3;
    localparam int GP = 2;

    localparam logic [4:0] PEND  = 5'b10000;
    localparam logic [4:0] SPILL = 5'b01000;
    localparam logic [4:0] EVNT  = 5'b00100;
    localparam logic [4:0] AFULL = 5'b00010;
    localparam logic [4:0] WARN  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       err_pending = 1'b0, err_spill = 1'b0, err_event = 1'b0, mem_afull = 1'b0, energy_err = 1'b0;
    logic [2:0] out_bus, s_out_bus;
    logic       busy, s_busy;
    logic [7:0] cnt_err, cnt_stop, cnt_warn;
    logic [1:0] s_cnt_err, s_cnt_stop, s_cnt_warn;

    error_encoder #(.MSG_LEN(ML), .GAP(GP), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .err_pending(err_pending), .err_spill(err_spill),
        .err_event(err_event), .mem_afull(mem_afull), .energy_err(energy_err),
        .out_bus(out_bus), .busy(busy), .cnt_err(cnt_err), .cnt_stop(cnt_stop), .cnt_warn(cnt_warn));

    error_encoder #(.MSG_LEN(ML), .GAP(GP), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .err_pending(err_pending), .err_spill(err_spill),
        .err_event(err_event), .mem_afull(mem_afull), .energy_err(energy_err),
        .out_bus(s_out_bus), .busy(s_busy), .cnt_err(s_cnt_err), .cnt_stop(s_cnt_stop), .cnt_warn(s_cnt_warn));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a launch at edge t owns the bus for edges t..t+ML-1 and blocks launches until t+ML+GP.
    int         m_edge = 0;
    int         m_launch = -1000;
    int         m_next_free = 0;
    logic [1:0] m_code = 2'b00;
    bit         m_pend [3];
    bit         m_prev = 0;
    int         m_cnt [3];
    logic [1:0] class_code [3] = '{2'b00, 2'b10, 2'b11};

    task automatic model_step(input logic r, input logic [4:0] req);
        m_edge++;
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                m_pend[k] = 0;
                m_cnt[k]  = 0;
            end
            m_prev      = 0;
            m_launch    = -1000;
            m_next_free = m_edge + 1;
            return;
        end
        if (m_edge >= m_next_free && (m_pend[0] || m_pend[1] || m_pend[2])) begin
            int k;
            k = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
            m_pend[k]   = 0;
            m_code      = class_code[k];
            m_launch    = m_edge;
            m_next_free = m_edge + ML + GP;
            m_cnt[k]++;
        end
        if (req[4] || req[3] || req[2]) m_pend[0] = 1;
        if (req[1] && !m_prev) m_pend[1] = 1;
        m_prev = req[1];
        if (req[0]) m_pend[2] = 1;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Independent run/gap monitor standing in for the decoder on the far side of the bus.
    int         mon_run = 0;
    int         mon_gap = 99;
    logic [1:0] mon_code = 2'b00;
    int         mon_cnt [3];

    function automatic int code_cls(input logic [1:0] c);
        return (c == 2'b00) ? 0 : ((c == 2'b10) ? 1 : 2);
    endfunction

    task automatic tick(input logic r, input logic [4:0] req);
        logic [2:0] exp_bus;
        logic       exp_busy;
        rst = r;
        {err_pending, err_spill, err_event, mem_afull, energy_err} = req;
        @(posedge clk);
        model_step(r, req);
        #1;
        exp_bus  = (m_edge - m_launch < ML) ? {1'b1, m_code} : 3'b000;
        exp_busy = (m_edge - m_launch < ML + GP);
        chk("out_bus", out_bus, exp_bus);
        chk("busy", busy, exp_busy);
        chk("cnt_err", cnt_err, sat(m_cnt[0], 255));
        chk("cnt_stop", cnt_stop, sat(m_cnt[1], 255));
        chk("cnt_warn", cnt_warn, sat(m_cnt[2], 255));
        chk("sat_out_bus", s_out_bus, exp_bus);
        chk("sat_cnt_err", s_cnt_err, sat(m_cnt[0], 3));
        chk("sat_cnt_stop", s_cnt_stop, sat(m_cnt[1], 3));
        chk("sat_cnt_warn", s_cnt_warn, sat(m_cnt[2], 3));
        if (r) begin
            mon_run = 0;
            mon_gap = 99;
        end else if (out_bus[2]) begin
            if (mon_run == 0) begin
                chk("gap_before_msg", int'(mon_gap >= GP), 1);
                mon_code = out_bus[1:0];
            end else begin
                chk("code_stable", out_bus[1:0], mon_code);
            end
            mon_run++;
        end else begin
            if (mon_run > 0) begin
                chk("run_len", mon_run, ML);
                mon_cnt[code_cls(mon_code)]++;
                mon_run = 0;
                mon_gap = 0;
            end
            mon_gap++;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] req);
        for (int i = 0; i < n; i++) tick(1'b0, req);
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [2:0] bus;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [4:0] req, input logic [2:0] b, input logic y, input int n);
        vec_t v;
        v.rst = r; v.req = req; v.bus = b; v.bsy = y;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Single pulse, then simultaneous ERROR/STOP/WARNING requests on one edge.
        add(1'b1, 5'b0, 3'b000, 1'b0, 1);
        add(1'b0, 5'b0, 3'b000, 1'b0, 1);
        add(1'b0, SPILL, 3'b000, 1'b0, 1);
        add(1'b0, 5'b0, 3'b100, 1'b1, 3);
        add(1'b0, 5'b0, 3'b000, 1'b1, 2);
        add(1'b0, 5'b0, 3'b000, 1'b0, 2);
        add(1'b0, WARN | EVNT | AFULL, 3'b000, 1'b0, 1);
        add(1'b0, AFULL, 3'b100, 1'b1, 3);
        add(1'b0, AFULL, 3'b000, 1'b1, 2);
        add(1'b0, AFULL, 3'b110, 1'b1, 3);
        add(1'b0, AFULL, 3'b000, 1'b1, 2);
        add(1'b0, AFULL, 3'b111, 1'b1, 3);
        add(1'b0, AFULL, 3'b000, 1'b1, 2);
        add(1'b0, 5'b0, 3'b000, 1'b0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].req);
            chk($sformatf("tbl_bus[%0d]", i), out_bus, vecs[i].bus);
            chk($sformatf("tbl_busy[%0d]", i), busy, vecs[i].bsy);
        end
        chk("tbl_cnt_err", cnt_err, 2);
        chk("tbl_cnt_stop", cnt_stop, 1);
        chk("tbl_cnt_warn", cnt_warn, 1);

        // Coalescing: four ERROR pulses during a WARNING message produce one ERROR message.
        tick(1'b1, 5'b0);
        tick(1'b0, WARN);
        tick(1'b0, 5'b0);
        chk("coal_warn_launch", out_bus, 3'b111);
        idle(4, PEND);
        tick(1'b0, 5'b0);
        tick(1'b0, 5'b0);
        chk("coal_err_launch", out_bus, 3'b100);
        idle(12, 5'b0);
        chk("coal_cnt_err", cnt_err, 1);
        chk("coal_cnt_warn", cnt_warn, 1);

        // Level input, already high while reset is held: one STOP per rising edge.
        tick(1'b1, AFULL);
        idle(50, AFULL);
        idle(5, 5'b0);
        idle(10, AFULL);
        idle(10, 5'b0);
        chk("level_cnt_stop", cnt_stop, 2);

        // Reset in mid-message aborts the bus and clears everything.
        tick(1'b1, 5'b0);
        tick(1'b0, PEND);
        tick(1'b0, 5'b0);
        chk("rstmid_launch", out_bus, 3'b100);
        tick(1'b1, 5'b0);
        chk("rstmid_bus", out_bus, 3'b000);
        chk("rstmid_cnt", cnt_err, 0);
        idle(4, 5'b0);
        chk("rstmid_no_pending", busy, 0);
        tick(1'b0, EVNT);
        idle(8, 5'b0);
        chk("rstmid_new_msg", cnt_err, 1);

        // Saturation on the 2-bit instance.
        tick(1'b1, 5'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, WARN);
            idle(6, 5'b0);
        end
        chk("sat_warn_wide", cnt_warn, 5);
        chk("sat_warn_narrow", s_cnt_warn, 3);

        // Random requests; every launched message must be seen exactly once by the monitor.
        tick(1'b1, 5'b0);
        for (int k = 0; k < 3; k++) mon_cnt[k] = 0;
        begin
            logic af;
            logic [4:0] req;
            af = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 7) == 0) af = ~af;
                req[4] = ($urandom_range(0, 15) == 0);
                req[3] = ($urandom_range(0, 15) == 0);
                req[2] = ($urandom_range(0, 15) == 0);
                req[1] = af;
                req[0] = ($urandom_range(0, 9) == 0);
                tick(1'b0, req);
            end
        end
        idle(40, 5'b0);
        chk("loop_err_msgs", mon_cnt[0], m_cnt[0]);
        chk("loop_stop_msgs", mon_cnt[1], m_cnt[1]);
        chk("loop_warn_msgs", mon_cnt[2], m_cnt[2]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/error_encoder.md
Name: error_encoder

Overview:
- Upstream stage of the error decoder; drives its 3-bit error message bus.
- Collects error sources from the front-end logic (pending, spill-number mismatch, event-number mismatch, memory almost-full, energy-word error) and latches them as per-class pending flags.
- Arbitrates by priority ERROR > STOP > WARNING and serialises one message at a time.
- Each message is held for MSG_LEN cycles, followed by GAP idle cycles, so the decoder's lock window is never violated.

Parameters:
- MSG_LEN, 3, cycles out_bus[2] is held high per message; must be 3 to match the decoder's lock length.
- GAP, 2, idle cycles (out_bus = 0) between consecutive messages; legal range >= 2.
- CNT_W, 8, width of the per-class sent-message counters.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- err_pending  input  1  single-cycle pulse; ERROR class
- err_spill  input  1  single-cycle pulse; ERROR class
- err_event  input  1  single-cycle pulse; ERROR class
- mem_afull  input  1  level; rising edge raises a STOP request
- energy_err  input  1  single-cycle pulse; WARNING class
- out_bus  output  3  [2] = message valid, [1:0] = code: 00 ERROR, 10 STOP, 11 WARNING; 01 never driven
- busy  output  1  high while in SEND or GAP
- cnt_err  output  CNT_W  ERROR messages sent, saturating
- cnt_stop  output  CNT_W  STOP messages sent, saturating
- cnt_warn  output  CNT_W  WARNING messages sent, saturating

Behaviour:
- Reset (sampled on a clk edge with rst = 1):
  - out_bus = 3'b000, busy = 0, all counters = 0.
  - pend_err, pend_stop, pend_warn cleared; afull_prev = 0; state = IDLE.
  - A reset in mid-message or mid-gap aborts immediately: out_bus is 0 on the cycle after the reset edge.
- Request latching, every edge:
  - pend_err sets on err_pending | err_spill | err_event.
  - pend_stop sets on mem_afull & ~afull_prev. If mem_afull is already high when reset releases, one STOP is raised.
  - pend_warn sets on energy_err.
  - Repeated requests of a class that is already pending coalesce into a single message.
- Arbitration: the grant goes to the highest-priority pending class. A pending flag clears on its grant edge, unless a new request of the same class arrives on that same edge; set wins, and another message follows later.
- FSM, all outputs registered:
  - IDLE: out_bus = 0. If any flag is pending, the next edge loads out_bus = {1, code}, enters SEND, and increments that class's counter (saturating at 2^CNT_W-1).
  - SEND: out_bus is held constant for exactly MSG_LEN cycles; the code never changes mid-message. After MSG_LEN cycles, enter GAP with out_bus = 0.
  - GAP: lasts exactly GAP cycles. On the edge that ends the last GAP cycle:
    - if any flag is pending, launch directly into SEND (back-to-back spacing is exactly GAP idle cycles);
    - otherwise go to IDLE.
- Latency: a request pulse sampled at edge k while IDLE gives out_bus[2] = 1 from edge k+1.
- Preemption: higher-priority requests arriving during SEND/GAP never preempt. They win at the next launch.
- Starvation: a WARNING can wait indefinitely while ERROR/STOP keep arriving; this is accepted.
- Invariant: out_bus[2] high runs are exactly MSG_LEN cycles, separated by >= GAP zero cycles.

Test Plan:
- Single pulse: err_spill pulse at edge 10 -> out_bus = 3'b100 for edges 11-13, 3'b000 afterwards; cnt_err = 1; busy high for edges 11-15.
- Simultaneous requests: energy_err, err_event and a mem_afull rise all at edge 10 -> messages 100, 110, 111 launched at edges 11, 16, 21, each 3 cycles long with exactly 2 zero cycles between; each counter = 1.
- Coalescing: 4 err_pending pulses at edges 12-15 during a WARNING message launched at edge 11 -> exactly one 100 message at edge 16; cnt_err = 1.
- Level input: mem_afull held high for 50 cycles -> exactly one 110 message; drop then re-raise -> a second message; cnt_stop = 2.
- Reset mid-message: rst at edge 12 during a 100 message launched at edge 11 -> out_bus = 0 after edge 12, counters = 0, pending flags clear; a new pulse after reset gives a normal full message.
- Saturation and decoder loopback with CNT_W = 2: 5 WARNING messages -> cnt_warn = 3. With the encoder connected to the decoder, the decoder produces exactly one err/stop/warning pulse per message, with no drops or duplicates across 1000 random requests.
